de_port_arbiter: RTL and testbench
==================================

# de_port_arbiter

Two-requester arbiter sharing the single frame-store data-engine port (de_req/de_ack/de_addr/de_nbyte/de_rnw/de_w_data/de_r_data) between drawing engines, e.g. the line drawer (requester 0) and the dithering engine (requester 1). Each engine sees a private copy of the de_* handshake. The arbiter grants whole bursts of transfers, bounds burst length for fairness, and muxes address, byte-lane and data onto the shared port.

## Interface
- MAX_BURST, default 16: transfers (de_ack pulses) an owner may complete before it must yield to a waiting peer; legal range 1..255.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- r0_req, r1_req  in  1 each  requester wants the port; held high until its last ack.
- r0_ack, r1_ack  out  1 each  one-cycle pulse per completed transfer for that requester.
- r0_addr, r1_addr  in  18 each  word address.
- r0_nbyte, r1_nbyte  in  4 each  active-low byte-lane enables.
- r0_rnw, r1_rnw  in  1 each  1 = read, 0 = write.
- r0_w_data, r1_w_data  in  32 each  write data.
- r_data  out  32  read data, broadcast to both requesters (= de_r_data).
- de_req  out  1  shared port request.
- de_ack  in  1  shared port transfer-complete pulse.
- de_addr  out  18; de_nbyte  out  4; de_rnw  out  1; de_w_data  out  32: shared port signals.
- owner  out  2  current grant: 2'b00 none, 2'b01 requester 0, 2'b10 requester 1.

## Operation
- States: IDLE, GNT0, GNT1. Registers: state, burst_cnt (8 bits), last (last owner, 1 bit).
- Outputs are combinational from the registered state: in GNTi, de_req = ri_req, de_addr/de_nbyte/de_rnw/de_w_data = requester i's signals, ri_ack = de_ack, other ack = 0. In IDLE: de_req = 0, de_addr = 0, de_nbyte = 4'b1111, de_rnw = 1, de_w_data = 0, both acks = 0.
- IDLE: if only ri_req, go to GNTi. If both, pick per Configuration. burst_cnt <= 0.
- GNTi, ri_req low: release; go to GNTj if rj_req, else IDLE; burst_cnt <= 0.
- GNTi, de_ack high: burst_cnt increments. If the new count equals MAX_BURST and rj_req is high, switch to GNTj with burst_cnt <= 0. Otherwise stay; with no peer waiting, burst_cnt saturates at MAX_BURST.
- On every entry to GNTi, last <= i.
- A de_ack arriving in IDLE is discarded; no requester sees it.
- Requesters must not drop req before their pending ack. If one does, de_req falls with it and the grant is released; a late ack is discarded if in IDLE, or delivered to the new owner if already switched (protocol violation, not protected).

## Timing
- Reset values: state IDLE, burst_cnt 0, last 1 (requester 0 wins the first tie). Outputs take the IDLE values, owner = 0.
- Reset mid-burst drops de_req immediately (asynchronous).
- Grant latency: ri_req sampled high in IDLE gives de_req high on the next cycle, so there is 1 cycle from req to de_req.
- Handover: the switch edge is the one sampling the final de_ack or the req drop. The new owner drives de_req on the following cycle, with no IDLE bubble.
- ri_ack is combinational from de_ack, so it has zero added latency.
- Simultaneous req drop and de_ack on one edge: the ack is delivered, then the release happens.

## Configuration
- DE_ARB_RR_EN defined: round robin. On a tie in IDLE, and on burst-limit handover, the requester other than `last` wins.
- DE_ARB_RR_EN undefined: fixed priority. On a tie in IDLE, requester 0 wins. The burst limit still applies to requester 0, so requester 1 is never starved beyond MAX_BURST transfers. Requester 1 yields at MAX_BURST only to a waiting requester 0.

## Test plan
- Reset: assert rst_n = 0 mid-burst -> de_req = 0, owner = 0, acks = 0 within the same cycle. After release, r0_req high -> de_req high 1 cycle later, owner = 2'b01.
- Single requester: r1_req for 20 writes, addr 0x100.., MAX_BURST = 4, r0 idle -> 20 r1_ack pulses, no handover, de_addr tracks r1_addr, owner stays 2'b10.
- Contention, RR: both requesting continuously, MAX_BURST = 4 -> grants alternate in runs of exactly 4 acks. First run goes to requester 0. No idle cycle between runs.
- Fixed priority (macro off): same stimulus -> requester 0 wins the tie. Requester 1 gets the port only after 4 acks to requester 0 or after r0_req drops.
- Early release: r0 drops req after 2 acks while r1 is waiting -> owner = 2'b10 on the next edge, burst_cnt restarts at 0.
- Stray ack: pulse de_ack in IDLE -> r0_ack = r1_ack = 0, state unchanged. Read data check: de_r_data = 0xDEADBEEF -> r_data = 0xDEADBEEF in the same cycle.

Source files
------------

// File: rtl/de_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : de_port_arbiter
// Brief    : Two-requester burst arbiter for the shared frame-store
//            data-engine port. The owner keeps the port for whole bursts. It
//            must yield to a waiting peer after MAX_BURST acknowledged
//            transfers. Address, byte lanes and data are muxed from the owner.
// Build    : DE_ARB_RR_EN defined   -> round-robin tie break in IDLE.
//            DE_ARB_RR_EN undefined -> requester 0 wins IDLE ties.
// Revision : 1.0 - initial release
// ============================================================================
module de_port_arbiter #(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    output logic        r0_ack,
    input  logic [17:0] r0_addr,
    input  logic [3:0]  r0_nbyte,
    input  logic        r0_rnw,
    input  logic [31:0] r0_w_data,
    input  logic        r1_req,
    output logic        r1_ack,
    input  logic [17:0] r1_addr,
    input  logic [3:0]  r1_nbyte,
    input  logic        r1_rnw,
    input  logic [31:0] r1_w_data,
    output logic [31:0] r_data,
    output logic        de_req,
    input  logic        de_ack,
    output logic [17:0] de_addr,
    output logic [3:0]  de_nbyte,
    output logic        de_rnw,
    output logic [31:0] de_w_data,
    input  logic [31:0] de_r_data,
    output logic [1:0]  owner
);

    // State encoding doubles as the owner code seen on the port.
    localparam logic [1:0] c_IDLE      = 2'b00;
    localparam logic [1:0] c_GNT0      = 2'b01;
    localparam logic [1:0] c_GNT1      = 2'b10;
    localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);

    logic [1:0] r_state;
    logic [7:0] r_burst_cnt;
    logic       r_last;

    logic [1:0] w_state_nxt;
    logic [7:0] w_burst_cnt_nxt;
    logic [7:0] w_cnt_inc;
    logic [1:0] w_tie_winner;
    logic [1:0] w_peer_state;
    logic       w_own_req;
    logic       w_peer_req;

    // While granted, r_last always names the current owner, so the peer is
    // simply its complement. This also makes the burst-limit handover go to
    // "the requester other than last", as round robin requires.
    assign w_peer_state = r_last ? c_GNT0 : c_GNT1;
    assign w_peer_req   = r_last ? r0_req : r1_req;
    assign w_own_req    = r_last ? r1_req : r0_req;

    // Saturating burst count: once at the limit with nobody waiting, the
    // count holds so the next ack after a peer arrives triggers the handover.
    assign w_cnt_inc = (r_burst_cnt >= c_MAX_BURST) ? c_MAX_BURST
                                                    : r_burst_cnt + 8'd1;

`ifdef DE_ARB_RR_EN
    assign w_tie_winner = r_last ? c_GNT0 : c_GNT1;
`else
    assign w_tie_winner = c_GNT0;
`endif

    // Next-state and burst-count decision.
    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            c_IDLE: begin
                w_burst_cnt_nxt = 8'd0;
                if (r0_req && r1_req) begin
                    w_state_nxt = w_tie_winner;
                end else if (r0_req) begin
                    w_state_nxt = c_GNT0;
                end else if (r1_req) begin
                    w_state_nxt = c_GNT1;
                end
            end
            c_GNT0, c_GNT1: begin
                // A req drop wins over a coincident ack: the ack is still
                // delivered combinationally, then the grant is released.
                if (!w_own_req) begin
                    w_burst_cnt_nxt = 8'd0;
                    w_state_nxt     = w_peer_req ? w_peer_state : c_IDLE;
                end else if (de_ack) begin
                    if ((w_cnt_inc == c_MAX_BURST) && w_peer_req) begin
                        w_burst_cnt_nxt = 8'd0;
                        w_state_nxt     = w_peer_state;
                    end else begin
                        w_burst_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt     = c_IDLE;
                w_burst_cnt_nxt = 8'd0;
            end
        endcase
    end

    // State registers; last tracks the most recent grant for the tie break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_burst_cnt <= 8'd0;
            r_last      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            if (w_state_nxt == c_GNT0) begin
                r_last <= 1'b0;
            end else if (w_state_nxt == c_GNT1) begin
                r_last <= 1'b1;
            end
        end
    end

    // Shared-port mux from the registered grant; IDLE drives a benign read.
    always_comb begin
        de_req    = 1'b0;
        de_addr   = 18'd0;
        de_nbyte  = 4'b1111;
        de_rnw    = 1'b1;
        de_w_data = 32'd0;
        r0_ack    = 1'b0;
        r1_ack    = 1'b0;
        case (r_state)
            c_GNT0: begin
                de_req    = r0_req;
                de_addr   = r0_addr;
                de_nbyte  = r0_nbyte;
                de_rnw    = r0_rnw;
                de_w_data = r0_w_data;
                r0_ack    = de_ack;
            end
            c_GNT1: begin
                de_req    = r1_req;
                de_addr   = r1_addr;
                de_nbyte  = r1_nbyte;
                de_rnw    = r1_rnw;
                de_w_data = r1_w_data;
                r1_ack    = de_ack;
            end
            default: begin
                de_req = 1'b0;
            end
        endcase
    end

    assign r_data = de_r_data;
    assign owner  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_de_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_de_port_arbiter
// Brief    : Self-checking bench for de_port_arbiter (MAX_BURST = 4): a
//            scripted vector table, hand-written corner sequences, and a
//            randomized run against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_de_port_arbiter;

    localparam int MAXB = 4;
`ifdef DE_ARB_RR_EN
    localparam bit         RR        = 1'b1;
    localparam logic [1:0] TIE_OWNER = 2'b10;
`else
    localparam bit         RR        = 1'b0;
    localparam logic [1:0] TIE_OWNER = 2'b01;
`endif

    logic        clk;
    logic        rst_n;
    logic        r0_req, r1_req;
    logic        r0_ack, r1_ack;
    logic [17:0] r0_addr, r1_addr;
    logic [3:0]  r0_nbyte, r1_nbyte;
    logic        r0_rnw, r1_rnw;
    logic [31:0] r0_w_data, r1_w_data;
    logic [31:0] r_data;
    logic        de_req;
    logic        de_ack;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic        de_rnw;
    logic [31:0] de_w_data;
    logic [31:0] de_r_data;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;

    de_port_arbiter #(.MAX_BURST(MAXB)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_req    (r0_req),
        .r0_ack    (r0_ack),
        .r0_addr   (r0_addr),
        .r0_nbyte  (r0_nbyte),
        .r0_rnw    (r0_rnw),
        .r0_w_data (r0_w_data),
        .r1_req    (r1_req),
        .r1_ack    (r1_ack),
        .r1_addr   (r1_addr),
        .r1_nbyte  (r1_nbyte),
        .r1_rnw    (r1_rnw),
        .r1_w_data (r1_w_data),
        .r_data    (r_data),
        .de_req    (de_req),
        .de_ack    (de_ack),
        .de_addr   (de_addr),
        .de_nbyte  (de_nbyte),
        .de_rnw    (de_rnw),
        .de_w_data (de_w_data),
        .de_r_data (de_r_data),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 1'b0; r1_req = 1'b0; de_ack = 1'b0;
        r0_addr = 18'd0; r1_addr = 18'd0;
        r0_nbyte = 4'hF; r1_nbyte = 4'hF;
        r0_rnw = 1'b1; r1_rnw = 1'b1;
        r0_w_data = 32'd0; r1_w_data = 32'd0;
        de_r_data = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- reference model (rule level) ----------------
    int m_owner;   // 0 none, 1 requester 0, 2 requester 1
    int m_cnt;
    int m_last;    // index of the last requester granted

    function automatic void model_reset();
        m_owner = 0;
        m_cnt   = 0;
        m_last  = 1;
    endfunction

    function automatic void model_step();
        int  old;
        bit  mine, other;
        old = m_owner;
        if (m_owner == 0) begin
            m_cnt = 0;
            if (r0_req && r1_req) m_owner = RR ? (m_last == 0 ? 2 : 1) : 1;
            else if (r0_req)      m_owner = 1;
            else if (r1_req)      m_owner = 2;
        end else begin
            mine  = (m_owner == 1) ? r0_req : r1_req;
            other = (m_owner == 1) ? r1_req : r0_req;
            if (!mine) begin
                m_cnt   = 0;
                m_owner = other ? 3 - m_owner : 0;
            end else if (de_ack) begin
                m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
                if (m_cnt == MAXB && other) begin
                    m_owner = 3 - m_owner;
                    m_cnt   = 0;
                end
            end
        end
        if (m_owner != 0 && m_owner != old) m_last = m_owner - 1;
    endfunction

    function automatic logic [91:0] model_out();
        logic [91:0] e;
        if (m_owner == 1)
            e = {r0_req, r0_addr, r0_nbyte, r0_rnw, r0_w_data, de_ack, 1'b0, de_r_data, 2'b01};
        else if (m_owner == 2)
            e = {r1_req, r1_addr, r1_nbyte, r1_rnw, r1_w_data, 1'b0, de_ack, de_r_data, 2'b10};
        else
            e = {1'b0, 18'd0, 4'hF, 1'b1, 32'd0, 1'b0, 1'b0, de_r_data, 2'b00};
        return e;
    endfunction

    // ---------------- scripted vector table ----------------
    typedef struct packed {
        logic       r0;
        logic       r1;
        logic       ack;
        logic [1:0] own;
        logic       dreq;
        logic       a0;
        logic       a1;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    initial begin
        int acks, mux_bad, own_bad;
        logic [91:0] act;

        //          r0    r1    ack   owner      de_req a0    a1
        vec[0]  = '{1'b0, 1'b0, 1'b0, 2'b00,     1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 1'b1, 2'b00,     1'b0, 1'b0, 1'b0};
        vec[2]  = '{1'b1, 1'b0, 1'b0, 2'b00,     1'b0, 1'b0, 1'b0};
        vec[3]  = '{1'b1, 1'b0, 1'b0, 2'b01,     1'b1, 1'b0, 1'b0};
        vec[4]  = '{1'b1, 1'b1, 1'b1, 2'b01,     1'b1, 1'b1, 1'b0};
        vec[5]  = '{1'b1, 1'b1, 1'b1, 2'b01,     1'b1, 1'b1, 1'b0};
        vec[6]  = '{1'b1, 1'b1, 1'b1, 2'b01,     1'b1, 1'b1, 1'b0};
        vec[7]  = '{1'b1, 1'b1, 1'b1, 2'b01,     1'b1, 1'b1, 1'b0};
        vec[8]  = '{1'b1, 1'b1, 1'b0, 2'b10,     1'b1, 1'b0, 1'b0};
        vec[9]  = '{1'b1, 1'b1, 1'b1, 2'b10,     1'b1, 1'b0, 1'b1};
        vec[10] = '{1'b1, 1'b0, 1'b1, 2'b10,     1'b0, 1'b0, 1'b1};
        vec[11] = '{1'b1, 1'b0, 1'b0, 2'b01,     1'b1, 1'b0, 1'b0};
        vec[12] = '{1'b0, 1'b0, 1'b0, 2'b01,     1'b0, 1'b0, 1'b0};
        vec[13] = '{1'b0, 1'b0, 1'b1, 2'b00,     1'b0, 1'b0, 1'b0};
        vec[14] = '{1'b1, 1'b1, 1'b0, 2'b00,     1'b0, 1'b0, 1'b0};
        vec[15] = '{1'b1, 1'b1, 1'b0, TIE_OWNER, 1'b1, 1'b0, 1'b0};
        vec[16] = '{1'b0, 1'b0, 1'b0, TIE_OWNER, 1'b0, 1'b0, 1'b0};
        vec[17] = '{1'b0, 1'b0, 1'b0, 2'b00,     1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("reset_outputs", 128'({de_req, de_addr, de_nbyte, de_rnw, de_w_data, r0_ack, r1_ack, owner}),
              128'({1'b0, 18'd0, 4'hF, 1'b1, 32'd0, 1'b0, 1'b0, 2'b00}));
        do_reset();

        // Table: inputs held for one cycle, outputs sampled mid-cycle.
        for (int i = 0; i < NV; i++) begin
            r0_req = vec[i].r0;
            r1_req = vec[i].r1;
            de_ack = vec[i].ack;
            #1;
            check($sformatf("vec%0d", i), 128'({owner, de_req, r0_ack, r1_ack}),
                  128'({vec[i].own, vec[i].dreq, vec[i].a0, vec[i].a1}));
            step();
        end

        // Asynchronous reset mid-burst, then grant latency.
        do_reset();
        r0_req = 1'b1;
        step();
        de_ack = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_burst", 128'({de_req, owner, r0_ack, r1_ack}), 128'(5'b0));
        de_ack = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("grant_latency_pre", 128'({de_req, owner}), 128'(3'b000));
        step();
        check("grant_latency", 128'({de_req, owner}), 128'(3'b101));

        // Single requester: 20 writes with no handover.
        do_reset();
        r1_req = 1'b1;
        r1_rnw = 1'b0;
        r1_addr = 18'h100;
        step();
        acks = 0; mux_bad = 0; own_bad = 0;
        for (int k = 0; k < 20; k++) begin
            r1_addr   = 18'h100 + 18'(k);
            r1_w_data = $urandom;
            r1_nbyte  = 4'($urandom);
            de_ack    = 1'b1;
            #1;
            if (r1_ack) acks++;
            if (r0_ack || owner != 2'b10 || !de_req) own_bad++;
            if (de_addr != r1_addr || de_w_data != r1_w_data || de_nbyte != r1_nbyte || de_rnw != 1'b0)
                mux_bad++;
            step();
        end
        r1_req = 1'b0;
        de_ack = 1'b0;
        check("single_ack_count", 128'(acks), 128'(20));
        check("single_owner_errs", 128'(own_bad), 128'(0));
        check("single_mux_errs", 128'(mux_bad), 128'(0));

        // Continuous contention: runs of exactly MAXB acks, requester 0 first.
        do_reset();
        r0_req = 1'b1;
        r1_req = 1'b1;
        step();
        de_ack = 1'b1;
        for (int k = 0; k < 6 * MAXB; k++) begin
            #1;
            check($sformatf("contend_ack%0d", k), 128'({r1_ack, r0_ack}),
                  128'((((k / MAXB) % 2) == 0) ? 2'b01 : 2'b10));
            step();
        end
        idle_inputs();

        // Early release after 2 acks; the new owner gets a full fresh burst.
        do_reset();
        r0_req = 1'b1;
        step();
        r1_req = 1'b1;
        de_ack = 1'b1;
        step();
        step();
        r0_req = 1'b0;
        de_ack = 1'b0;
        #1;
        check("early_drop_dereq", 128'({owner, de_req}), 128'(3'b010));
        step();
        check("early_owner", 128'(owner), 128'(2'b10));
        r0_req = 1'b1;
        de_ack = 1'b1;
        for (int k = 0; k <= MAXB; k++) begin
            #1;
            check($sformatf("early_burst%0d", k), 128'({r1_ack, r0_ack}),
                  128'((k < MAXB) ? 2'b10 : 2'b01));
            step();
        end
        idle_inputs();

        // Stray ack in IDLE and read-data broadcast.
        do_reset();
        de_ack    = 1'b1;
        de_r_data = 32'hDEADBEEF;
        #1;
        check("stray_ack", 128'({r0_ack, r1_ack, de_req}), 128'(3'b000));
        check("read_data", 128'(r_data), 128'(32'hDEADBEEF));
        step();
        check("stray_state", 128'(owner), 128'(2'b00));
        de_ack = 1'b0;

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            if (rst_n) model_step();
            #1;
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 11) == 0) r0_req = ~r0_req;
            if ($urandom_range(0, 11) == 0) r1_req = ~r1_req;
            de_ack    = $urandom_range(0, 1) == 1;
            r0_addr   = 18'($urandom);
            r1_addr   = 18'($urandom);
            r0_nbyte  = 4'($urandom);
            r1_nbyte  = 4'($urandom);
            r0_rnw    = 1'($urandom);
            r1_rnw    = 1'($urandom);
            r0_w_data = $urandom;
            r1_w_data = $urandom;
            de_r_data = $urandom;
            if (!rst_n) model_reset();
            #1;
            act = {de_req, de_addr, de_nbyte, de_rnw, de_w_data, r0_ack, r1_ack, r_data, owner};
            check($sformatf("rand%0d", n), 128'(act), 128'(model_out()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
